fetch_prefetch_unit: RTL and testbench



---
 rtl/fetch_prefetch_unit_pkg.sv | 27 ++
 rtl/fetch_prefetch_unit_fifo.sv | 73 +++++++
 rtl/fetch_prefetch_unit.sv | 73 +++++++
 tb/tb_fetch_prefetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and constants for the fetch/prefetch stage.
// The rv32i defaults below can be overridden by an earlier shared define.
`ifndef RV32I_RESET_PC
`define RV32I_RESET_PC 32'h0000_0000
`endif
`ifndef RV32I_INSTR_BYTES
`define RV32I_INSTR_BYTES 4
`endif

package fetch_prefetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = `RV32I_RESET_PC;
    localparam logic [31:0] INSTR_BYTES      = 32'(`RV32I_INSTR_BYTES);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Instruction fetch is always word aligned; low address bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Synchronous FIFO for prefetched instructions with a flush input and a
// combinational head read.
module fetch_prefetch_unit_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; a zero count hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Program counter and prefetch buffer sitting around a combinational
// instruction memory, feeding decode over a valid/ready handshake.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    logic [31:0]          fetch_pc_q, fetch_pc_d;
    logic                 push, pop;
    logic                 fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    fetch_entry_t         wr_entry, head_entry;

    // A redirect suppresses both handshake sides; a full buffer may still
    // accept a new word when the head leaves in the same cycle.
    assign instr_valid = (fifo_count != '0) & ~redirect_valid;
    assign pop         = instr_valid & instr_ready & ~redirect_valid;
    assign push        = ~redirect_valid & (~fifo_full | pop);

    assign wr_entry.pc   = fetch_pc_q;
    assign wr_entry.word = imem_data;

    fetch_prefetch_unit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign imem_addr = fetch_pc_q;
    assign instr     = fifo_empty ? 32'h0 : head_entry.word;
    assign instr_pc  = fifo_empty ? 32'h0 : head_entry.pc;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_fetch_prefetch_unit;

    localparam int unsigned DEPTH   = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } model_entry_t;

    logic        clk;
    logic        rstN;
    logic [31:0] imemAddr, imemData;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        instrValid, instrReady;
    logic [31:0] instrWord, instrPc;

    logic [31:0] imem2Addr, imem2Data;
    logic        instr2Valid;
    logic [31:0] instr2Word, instr2Pc;

    int checksRun    = 0;
    int checksPassed = 0;

    model_entry_t modelQ[$];
    logic [31:0]  modelPc = 32'h0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_1234;
    endfunction

    assign imemData  = memWord(imemAddr);
    assign imem2Data = memWord(imem2Addr);

    fetch_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rstN),
        .imem_addr      (imemAddr),
        .imem_data      (imemData),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .instr_valid    (instrValid),
        .instr_ready    (instrReady),
        .instr          (instrWord),
        .instr_pc       (instrPc)
    );

    fetch_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (WRAP_PC)
    ) dutWrap (
        .clk            (clk),
        .rst_n          (rstN),
        .imem_addr      (imem2Addr),
        .imem_data      (imem2Data),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .instr_valid    (instr2Valid),
        .instr_ready    (1'b1),
        .instr          (instr2Word),
        .instr_pc       (instr2Pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checksRun = checksRun + 1;
        if (actual === expected) begin
            checksPassed = checksPassed + 1;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic ready,
                                 input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rstN          = rstVal;
        instrReady    = ready;
        redirectValid = redir;
        redirectPc    = rpc;
    endtask

    // Reference model: a plain queue of {pc, word} plus a fetch address,
    // evaluated once per cycle between clock edges.
    always @(negedge clk) begin
        logic        expValid, doPop, doPush;
        if (!rstN) begin
            modelQ.delete();
            modelPc = 32'h0;
        end
        expValid = (modelQ.size() != 0) && !redirectValid;
        checkOutput("modelValid", {31'h0, instrValid}, {31'h0, expValid});
        checkOutput("modelInstr", instrWord, (modelQ.size() != 0) ? modelQ[0].word : 32'h0);
        checkOutput("modelPc", instrPc, (modelQ.size() != 0) ? modelQ[0].pc : 32'h0);
        checkOutput("modelAddr", imemAddr, modelPc);
        if (rstN) begin
            if (redirectValid) begin
                modelQ.delete();
                modelPc = redirectPc & 32'hFFFF_FFFC;
            end else begin
                doPop  = expValid && instrReady;
                doPush = (modelQ.size() < DEPTH) || doPop;
                if (doPop) void'(modelQ.pop_front());
                if (doPush) begin
                    modelQ.push_back('{pc: modelPc, word: memWord(modelPc)});
                    modelPc = modelPc + 32'd4;
                end
            end
        end
    end

    initial begin
        logic [31:0] wrapSeq [4];
        wrapSeq[0] = 32'hFFFF_FFF8;
        wrapSeq[1] = 32'hFFFF_FFFC;
        wrapSeq[2] = 32'h0000_0000;
        wrapSeq[3] = 32'h0000_0004;

        rstN          = 1'b0;
        instrReady    = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstAddr", imemAddr, 32'h0);
        checkOutput("rstValid", {31'h0, instrValid}, 32'h0);
        checkOutput("rstInstr", instrWord, 32'h0);
        checkOutput("rstWrapAddr", imem2Addr, WRAP_PC);

        // Streaming after reset, plus PC wrap on the second instance
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("firstLatency", {31'h0, instrValid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("streamValid", {31'h0, instrValid}, 32'h1);
            checkOutput("streamPc", instrPc, 32'(4 * k));
            checkOutput("streamInstr", instrWord, memWord(32'(4 * k)));
            checkOutput("wrapValid", {31'h0, instr2Valid}, 32'h1);
            checkOutput("wrapPc", instr2Pc, wrapSeq[k]);
            checkOutput("wrapInstr", instr2Word, memWord(wrapSeq[k]));
        end

        // Stall fills the buffer, then drain without gaps
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("fullAddr", imemAddr, 32'h10);
        checkOutput("fullHeadPc", instrPc, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("drainValid", {31'h0, instrValid}, 32'h1);
            checkOutput("drainPc", instrPc, 32'(4 * k));
        end

        // Redirect while full
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        @(negedge clk);
        checkOutput("redirValidSame", {31'h0, instrValid}, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("redirValidNext", {31'h0, instrValid}, 32'h0);
        checkOutput("redirAddr", imemAddr, 32'h200);
        @(negedge clk);
        checkOutput("redirFirstPc", instrPc, 32'h200);
        @(negedge clk);
        checkOutput("redirSecondPc", instrPc, 32'h204);

        // Random ready with periodic redirects, checked by the model
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), (i % 17) == 16, $urandom);
        end

        // Asynchronous reset with three entries buffered
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("preRstValid", {31'h0, instrValid}, 32'h1);
        checkOutput("preRstAddr", imemAddr, 32'hC);
        @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("asyncRstValid", {31'h0, instrValid}, 32'h0);
        checkOutput("asyncRstAddr", imemAddr, 32'h0);
        checkOutput("asyncRstPc", instrPc, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("resumeEmpty", {31'h0, instrValid}, 32'h0);
        @(negedge clk);
        checkOutput("resumePc", instrPc, 32'h0);
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
